param_ring_fsm: RTL

Parametrised successor to the small 2-bit test FSMs. It is a ring sequencer with NUM_STATES legal states, all of them reachable. It supports:
- up or down stepping,
- a per-state dwell count,
- synchronous load of an arbitrary state,
- defined recovery from out-of-range encodings.

It serves as a reusable sequencing core and as a known-good FSM reference for the lint flow.

---
 rtl/param_ring_fsm.sv | 123 ++++++++++++
 1 files changed

// File: rtl/param_ring_fsm.sv
// Ring sequencer over NUM_STATES legal states with up/down stepping, per-state dwell,
// synchronous load and recovery from illegal encodings. Optional one-hot output: PARAM_RING_FSM_ONEHOT_EN.
module param_ring_fsm #(
  parameter int NUM_STATES = 3,
  parameter int STATE_W    = 2,
  parameter int DWELL      = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               dir,
  input  logic               load,
  input  logic [STATE_W-1:0] load_state,
  input  logic               clr_err,
  output logic [STATE_W-1:0] state,
  output logic               wrap,
  output logic               err
`ifdef PARAM_RING_FSM_ONEHOT_EN
  ,
  output logic [NUM_STATES-1:0] state_oh
`endif
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [STATE_W-1:0] LAST     = STATE_W'(NUM_STATES - 1);
  localparam logic [STATE_W:0]   LIMIT    = (STATE_W + 1)'(NUM_STATES);

  logic [STATE_W-1:0] state_reg, state_nxt;
  logic [CNT_W-1:0]   cnt_reg, cnt_nxt;
  logic               wrap_reg, wrap_nxt;
  logic               err_reg, err_nxt;
  logic               err_set;

  function automatic logic is_legal(input logic [STATE_W-1:0] s);
    return {1'b0, s} < LIMIT;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= '0;
      cnt_reg   <= '0;
      wrap_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_nxt;
      cnt_reg   <= cnt_nxt;
      wrap_reg  <= wrap_nxt;
      err_reg   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state_reg;
    cnt_nxt   = cnt_reg;
    wrap_nxt  = 1'b0;
    err_set   = 1'b0;
    if (!is_legal(state_reg)) begin
      state_nxt = '0;
      cnt_nxt   = '0;
      err_set   = 1'b1;
    end else if (load) begin
      cnt_nxt = '0;
      if (is_legal(load_state)) begin
        state_nxt = load_state;
      end else begin
        state_nxt = '0;
        err_set   = 1'b1;
      end
    end else if (en) begin
      if (cnt_reg == CNT_LAST) begin
        cnt_nxt = '0;
        // dir only matters here, at the stepping edge
        if (!dir) begin
          if (state_reg == LAST) begin
            state_nxt = '0;
            wrap_nxt  = 1'b1;
          end else begin
            state_nxt = state_reg + 1'b1;
          end
        end else begin
          if (state_reg == '0) begin
            state_nxt = LAST;
            wrap_nxt  = 1'b1;
          end else begin
            state_nxt = state_reg - 1'b1;
          end
        end
      end else begin
        cnt_nxt = cnt_reg + 1'b1;
      end
    end
    // a new error on the same edge as clr_err keeps err set
    err_nxt = (err_reg & ~clr_err) | err_set;
  end

  always_comb begin
    state = state_reg;
    wrap  = wrap_reg;
    err   = err_reg;
  end

`ifdef PARAM_RING_FSM_ONEHOT_EN
  logic [NUM_STATES-1:0] oh_reg, oh_nxt;

  always_comb begin
    oh_nxt = '0;
    for (int i = 0; i < NUM_STATES; i++) begin
      if ({1'b0, state_nxt} == (STATE_W + 1)'(i)) oh_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) oh_reg <= NUM_STATES'(1);
    else        oh_reg <= oh_nxt;
  end

  assign state_oh = oh_reg;
`else
  // no one-hot decode in this build
`endif

endmodule
